// File: rtl/eth_tx_framer.sv
// Gigabit Ethernet transmit framer: wraps an accepted byte stream with preamble/SFD,
// minimum-length padding, CRC-32 FCS and the inter-frame gap, one byte per tx_clk.
module eth_tx_framer #(
    parameter int IFG_BYTES = 12,
    parameter int PAD_EN    = 1
) (
    input  logic       tx_clk,
    input  logic       rst_n,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    input  logic       in_last,
    output logic       in_ready,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    output logic       busy,
    output logic       frame_done,
    output logic       underrun,
    output logic [2:0] state_dbg
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_PRE  = 3'd1;
    localparam logic [2:0] S_DATA = 3'd2;
    localparam logic [2:0] S_PAD  = 3'd3;
    localparam logic [2:0] S_FCS  = 3'd4;
    localparam logic [2:0] S_IFG  = 3'd5;

    localparam logic [31:0] CRC_POLY = 32'hEDB8_8320;
    localparam logic [31:0] CRC_INIT = 32'hFFFF_FFFF;
    localparam logic [10:0] MIN_LEN  = 11'd60;
    localparam logic [10:0] CNT_MAX  = 11'd2047;
    localparam logic [7:0]  IFG_LAST = 8'(IFG_BYTES - 1);
    localparam bit          PAD_ON   = (PAD_EN != 0);

    // Reflected CRC-32, one byte per call, LSB of the byte processed first.
    function automatic logic [31:0] crc_byte(input logic [31:0] crc_in, input logic [7:0] d);
        logic [31:0] c;
        c = crc_in ^ {24'd0, d};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
        end
        return c;
    endfunction

    logic [2:0]  state;
    logic [31:0] crc;
    logic [10:0] byte_cnt;
    logic [7:0]  sub_cnt;

    logic [10:0] cnt_inc;
    logic [31:0] fcs;
    logic [7:0]  fcs_byte;
    logic [31:0] crc_in_next;
    logic [31:0] crc_pad_next;

    assign cnt_inc      = (byte_cnt == CNT_MAX) ? byte_cnt : byte_cnt + 11'd1;
    assign fcs          = ~crc;
    assign crc_in_next  = crc_byte(crc, in_data);
    assign crc_pad_next = crc_byte(crc, 8'h00);

    always_comb begin
        fcs_byte = fcs[7:0];
        case (sub_cnt[1:0])
            2'd0:    fcs_byte = fcs[7:0];
            2'd1:    fcs_byte = fcs[15:8];
            2'd2:    fcs_byte = fcs[23:16];
            default: fcs_byte = fcs[31:24];
        endcase
    end

    // Handshake: a byte transfers on a rising edge where in_valid and in_ready are both
    // high. in_ready is a function of state alone (high only in DATA); in_valid low while
    // in_ready is high is not a stall but an underrun that aborts the frame.
    assign in_ready  = (state == S_DATA);
    assign busy      = (state != S_IDLE);
    assign state_dbg = state;

    always_ff @(posedge tx_clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            crc        <= CRC_INIT;
            byte_cnt   <= 11'd0;
            sub_cnt    <= 8'd0;
            tx_data    <= 8'h00;
            tx_valid   <= 1'b0;
            frame_done <= 1'b0;
            underrun   <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            underrun   <= 1'b0;
            case (state)
                S_IDLE: begin
                    tx_valid <= 1'b0;
                    tx_data  <= 8'h00;
                    if (in_valid) begin
                        state    <= S_PRE;
                        tx_data  <= 8'h55;
                        tx_valid <= 1'b1;
                        crc      <= CRC_INIT;
                        byte_cnt <= 11'd0;
                        sub_cnt  <= 8'd1;
                    end
                end
                S_PRE: begin
                    // sub_cnt holds the number of preamble bytes already registered
                    if (sub_cnt == 8'd7) begin
                        tx_data <= 8'hD5;
                        state   <= S_DATA;
                        sub_cnt <= 8'd0;
                    end else begin
                        tx_data <= 8'h55;
                        sub_cnt <= sub_cnt + 8'd1;
                    end
                end
                S_DATA: begin
                    if (in_valid) begin
                        tx_data  <= in_data;
                        crc      <= crc_in_next;
                        byte_cnt <= cnt_inc;
                        if (in_last) begin
                            sub_cnt <= 8'd0;
                            if (PAD_ON && (cnt_inc < MIN_LEN)) begin
                                state <= S_PAD;
                            end else begin
                                state <= S_FCS;
                            end
                        end
                    end else begin
                        tx_valid <= 1'b0;
                        tx_data  <= 8'h00;
                        underrun <= 1'b1;
                        state    <= S_IFG;
                        sub_cnt  <= 8'd0;
                    end
                end
                S_PAD: begin
                    tx_data  <= 8'h00;
                    crc      <= crc_pad_next;
                    byte_cnt <= cnt_inc;
                    if (cnt_inc == MIN_LEN) begin
                        state <= S_FCS;
                    end
                end
                S_FCS: begin
                    tx_data <= fcs_byte;
                    if (sub_cnt == 8'd3) begin
                        frame_done <= 1'b1;
                        state      <= S_IFG;
                        sub_cnt    <= 8'd0;
                    end else begin
                        sub_cnt <= sub_cnt + 8'd1;
                    end
                end
                S_IFG: begin
                    tx_valid <= 1'b0;
                    tx_data  <= 8'h00;
                    if (sub_cnt == IFG_LAST) begin
                        state   <= S_IDLE;
                        sub_cnt <= 8'd0;
                    end else begin
                        sub_cnt <= sub_cnt + 8'd1;
                    end
                end
                default: begin
                    state    <= S_IDLE;
                    tx_valid <= 1'b0;
                    tx_data  <= 8'h00;
                    sub_cnt  <= 8'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_eth_tx_framer.sv
// Self-checking bench for eth_tx_framer: random frames against a wire-image model
// (preamble, padding, bitwise CRC-32 FCS) plus timing checks on handshake and gaps.
module tb_eth_tx_framer;

    localparam int IFG = 12;

    typedef logic [7:0] byte_q_t[$];
    typedef bit         bit_q_t[$];
    typedef int         int_q_t[$];

    logic       tx_clk = 1'b0;
    logic       rst_n;
    logic [7:0] in_data[2];
    logic       in_valid[2];
    logic       in_last[2];
    logic       in_ready_w[2];
    logic [7:0] tx_data_w[2];
    logic       tx_valid_w[2];
    logic       busy_w[2];
    logic       frame_done_w[2];
    logic       underrun_w[2];
    logic [2:0] state_w[2];

    eth_tx_framer #(.IFG_BYTES(IFG), .PAD_EN(1)) dut_pad (
        .tx_clk(tx_clk), .rst_n(rst_n),
        .in_data(in_data[0]), .in_valid(in_valid[0]), .in_last(in_last[0]),
        .in_ready(in_ready_w[0]), .tx_data(tx_data_w[0]), .tx_valid(tx_valid_w[0]),
        .busy(busy_w[0]), .frame_done(frame_done_w[0]), .underrun(underrun_w[0]),
        .state_dbg(state_w[0])
    );

    eth_tx_framer #(.IFG_BYTES(IFG), .PAD_EN(0)) dut_nopad (
        .tx_clk(tx_clk), .rst_n(rst_n),
        .in_data(in_data[1]), .in_valid(in_valid[1]), .in_last(in_last[1]),
        .in_ready(in_ready_w[1]), .tx_data(tx_data_w[1]), .tx_valid(tx_valid_w[1]),
        .busy(busy_w[1]), .frame_done(frame_done_w[1]), .underrun(underrun_w[1]),
        .state_dbg(state_w[1])
    );

    // ---------------- clock / reset ----------------
    always #4 tx_clk = ~tx_clk;

    int cyc = 0;
    always @(posedge tx_clk) cyc <= cyc + 1;

    // ---------------- scoreboard state ----------------
    int         errors = 0;
    int         checks = 0;
    int         mon_u = 0;
    int         idle_cyc = 0;
    logic [2:0] idle_state;
    logic [7:0] exp_q[$];
    logic [7:0] cap_q[$];
    int         cap_t[$];
    int         done_t[$];
    logic [7:0] done_b[$];
    int         urun_t[$];
    int         rdy_t[$];

    // Output monitor, sampled on the falling edge of the selected instance
    always @(negedge tx_clk) begin
        if (tx_valid_w[mon_u] === 1'b1) begin
            cap_q.push_back(tx_data_w[mon_u]);
            cap_t.push_back(cyc);
        end
        if (frame_done_w[mon_u] === 1'b1) begin
            done_t.push_back(cyc);
            done_b.push_back(tx_data_w[mon_u]);
        end
        if (underrun_w[mon_u] === 1'b1) urun_t.push_back(cyc);
        if (in_ready_w[mon_u] === 1'b1) rdy_t.push_back(cyc);
    end

    // ---------------- reference model ----------------
    function automatic logic [31:0] crc_raw(input byte_q_t b, input int from);
        logic [31:0] c;
        bit fb;
        c = 32'hFFFF_FFFF;
        for (int i = from; i < b.size(); i++) begin
            for (int k = 0; k < 8; k++) begin
                fb = c[0] ^ b[i][k];
                c  = c >> 1;
                if (fb) c = c ^ 32'hEDB8_8320;
            end
        end
        return c;
    endfunction

    function automatic byte_q_t wire_image(input byte_q_t f, input bit pad);
        byte_q_t w;
        byte_q_t body;
        logic [31:0] fcs;
        body = f;
        if (pad) while (body.size() < 60) body.push_back(8'h00);
        fcs = ~crc_raw(body, 0);
        repeat (7) w.push_back(8'h55);
        w.push_back(8'hD5);
        foreach (body[i]) w.push_back(body[i]);
        for (int k = 0; k < 4; k++) w.push_back(fcs[8*k +: 8]);
        return w;
    endfunction

    function automatic byte_q_t make_frame(input int n);
        byte_q_t f;
        for (int i = 0; i < n; i++) f.push_back(8'($urandom_range(0, 255)));
        return f;
    endfunction

    function automatic bit_q_t lasts_for(input int n);
        bit_q_t l;
        for (int i = 0; i < n; i++) l.push_back(i == n - 1);
        return l;
    endfunction

    function automatic int first_diff(input byte_q_t a, input byte_q_t b);
        int n;
        n = (a.size() < b.size()) ? a.size() : b.size();
        for (int i = 0; i < n; i++) if (a[i] !== b[i]) return i;
        if (a.size() != b.size()) return n;
        return -1;
    endfunction

    function automatic int gap_count(input int_q_t t);
        int g;
        g = 0;
        for (int i = 1; i < t.size(); i++) if (t[i] != t[i-1] + 1) g++;
        return g;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic clear_mon();
        cap_q.delete(); cap_t.delete(); done_t.delete(); done_b.delete();
        urun_t.delete(); rdy_t.delete(); exp_q.delete();
    endtask

    task automatic drive(input int u, input byte_q_t bytes, input bit_q_t lasts, input int abort_after);
        int i;
        int guard;
        bit hs;
        i = 0;
        guard = 0;
        in_valid[u] = 1'b1;
        in_data[u]  = bytes[0];
        in_last[u]  = lasts[0];
        while (i < bytes.size()) begin
            @(negedge tx_clk);
            hs = (in_ready_w[u] === 1'b1) && in_valid[u];
            @(posedge tx_clk);
            #1;
            guard++;
            if (hs) begin
                i++;
                if (abort_after >= 0 && i == abort_after) begin
                    i = bytes.size();
                end else if (i < bytes.size()) begin
                    in_data[u] = bytes[i];
                    in_last[u] = lasts[i];
                end
            end
            if (guard > 5000) begin
                checks++; errors++;
                $display("FAIL drive_timeout: accepted %0d of %0d bytes", i, bytes.size());
                i = bytes.size();
            end
        end
        in_valid[u] = 1'b0;
        in_last[u]  = 1'b0;
    endtask

    task automatic wait_quiet(input int n_done, input int n_urun);
        int guard;
        bit ok;
        guard = 0;
        ok = 1'b0;
        while (!ok && guard < 4000) begin
            @(negedge tx_clk);
            guard++;
            ok = (done_t.size() >= n_done) && (urun_t.size() >= n_urun) && (busy_w[mon_u] === 1'b0);
        end
        idle_cyc = cyc;
        if (!ok) begin
            checks++; errors++;
            $display("FAIL wait_quiet: timeout done=%0d need %0d urun=%0d need %0d",
                     done_t.size(), n_done, urun_t.size(), n_urun);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        for (int u = 0; u < 2; u++) begin
            in_valid[u] = 1'b0; in_last[u] = 1'b0; in_data[u] = 8'h00;
        end
        repeat (3) @(posedge tx_clk);
        @(negedge tx_clk);
        for (int u = 0; u < 2; u++) begin
            checks++;
            if (tx_valid_w[u] !== 1'b0 || tx_data_w[u] !== 8'h00 || in_ready_w[u] !== 1'b0 ||
                busy_w[u] !== 1'b0 || frame_done_w[u] !== 1'b0 || underrun_w[u] !== 1'b0) begin
                errors++;
                $display("FAIL reset_outputs u%0d: got v=%b d=%h rdy=%b busy=%b done=%b urun=%b, need all 0",
                         u, tx_valid_w[u], tx_data_w[u], in_ready_w[u], busy_w[u], frame_done_w[u], underrun_w[u]);
            end
        end
        idle_state = state_w[0];
        rst_n = 1'b1;
        repeat (3) @(negedge tx_clk);
        checks++;
        if (busy_w[0] !== 1'b0 || tx_valid_w[0] !== 1'b0) begin
            errors++;
            $display("FAIL idle_hold: got busy=%b v=%b, need 0 0", busy_w[0], tx_valid_w[0]);
        end
    endtask

    task automatic test_crc_check();
        byte_q_t f;
        logic [7:0] fcs_ref[4];
        int d;
        fcs_ref = '{8'h26, 8'h39, 8'hF4, 8'hCB};
        mon_u = 1;
        clear_mon();
        for (int i = 0; i < 9; i++) f.push_back(8'h31 + 8'(i));
        exp_q = wire_image(f, 1'b0);
        drive(1, f, lasts_for(9), -1);
        wait_quiet(1, 0);
        d = first_diff(cap_q, exp_q);
        checks++;
        if (d != -1) begin
            errors++;
            $display("FAIL crc_stream: idx %0d got %h need %h (len %0d vs %0d)", d, cap_q[d], exp_q[d], cap_q.size(), exp_q.size());
        end
        checks++;
        d = 0;
        for (int k = 0; k < 4; k++) if (cap_q.size() < 21 || cap_q[17+k] !== fcs_ref[k]) d++;
        if (d != 0) begin
            errors++;
            $display("FAIL crc_check_value: %0d FCS bytes differ from 26 39 F4 CB", d);
        end
        checks++;
        if (done_t.size() != 1 || done_b[0] !== 8'hCB) begin
            errors++;
            $display("FAIL crc_done: got %0d pulses byte %h, need 1 with CB", done_t.size(), done_b[0]);
        end
        checks++;
        if (done_t.size() < 1 || idle_cyc - done_t[0] != IFG || gap_count(cap_t) != 0) begin
            errors++;
            $display("FAIL crc_ifg: got idle after %0d gaps %0d, need %0d and 0",
                     idle_cyc - done_t[0], gap_count(cap_t), IFG);
        end
        mon_u = 0;
    endtask

    task automatic test_padding();
        byte_q_t f;
        int d;
        clear_mon();
        f = make_frame(24);
        exp_q = wire_image(f, 1'b1);
        drive(0, f, lasts_for(24), -1);
        wait_quiet(1, 0);
        d = first_diff(cap_q, exp_q);
        checks++;
        if (d != -1) begin
            errors++;
            $display("FAIL pad_stream: idx %0d got %h need %h", d, cap_q[d], exp_q[d]);
        end
        checks++;
        if (cap_q.size() != 72 || gap_count(cap_t) != 0) begin
            errors++;
            $display("FAIL pad_len: got %0d bytes %0d gaps, need 72 and 0", cap_q.size(), gap_count(cap_t));
        end
        checks++;
        if (crc_raw(cap_q, 8) !== 32'hDEBB_20E3) begin
            errors++;
            $display("FAIL pad_residue: got %h need DEBB20E3", crc_raw(cap_q, 8));
        end
        checks++;
        if (rdy_t.size() == 0 || cap_t.size() == 0 || rdy_t[0] != cap_t[0] + 7) begin
            errors++;
            $display("FAIL ready_rise: got offset %0d need 7", (rdy_t.size() > 0 && cap_t.size() > 0) ? rdy_t[0] - cap_t[0] : -1);
        end
        checks++;
        if (done_t.size() != 1 || cap_t.size() == 0 || done_t[0] != cap_t[cap_t.size()-1]) begin
            errors++;
            $display("FAIL pad_done: got %0d pulses, need 1 on last FCS byte", done_t.size());
        end
    endtask

    task automatic test_boundary();
        int lens[2];
        byte_q_t f;
        int d;
        lens = '{60, 1514};
        for (int j = 0; j < 2; j++) begin
            clear_mon();
            f = make_frame(lens[j]);
            exp_q = wire_image(f, 1'b1);
            drive(0, f, lasts_for(lens[j]), -1);
            wait_quiet(1, 0);
            d = first_diff(cap_q, exp_q);
            checks++;
            if (d != -1 || cap_q.size() != lens[j] + 12) begin
                errors++;
                $display("FAIL boundary_%0d: idx %0d len %0d need %0d", lens[j], d, cap_q.size(), lens[j] + 12);
            end
            checks++;
            if (crc_raw(cap_q, 8) !== 32'hDEBB_20E3) begin
                errors++;
                $display("FAIL boundary_residue_%0d: got %h need DEBB20E3", lens[j], crc_raw(cap_q, 8));
            end
        end
    endtask

    task automatic test_back_to_back();
        byte_q_t f1, f2, w1, w2, all_b;
        bit_q_t l1, l2, all_l;
        int d, n1;
        clear_mon();
        f1 = make_frame(64); f2 = make_frame(70);
        l1 = lasts_for(64);  l2 = lasts_for(70);
        w1 = wire_image(f1, 1'b1); w2 = wire_image(f2, 1'b1);
        foreach (w1[i]) exp_q.push_back(w1[i]);
        foreach (w2[i]) exp_q.push_back(w2[i]);
        foreach (f1[i]) begin all_b.push_back(f1[i]); all_l.push_back(l1[i]); end
        foreach (f2[i]) begin all_b.push_back(f2[i]); all_l.push_back(l2[i]); end
        drive(0, all_b, all_l, -1);
        wait_quiet(2, 0);
        n1 = w1.size();
        d = first_diff(cap_q, exp_q);
        checks++;
        if (d != -1) begin
            errors++;
            $display("FAIL b2b_stream: idx %0d got %h need %h", d, cap_q[d], exp_q[d]);
        end
        checks++;
        if (cap_t.size() <= n1 || cap_t[n1] - cap_t[n1-1] != IFG + 1) begin
            errors++;
            $display("FAIL b2b_gap: got %0d need %0d", (cap_t.size() > n1) ? cap_t[n1] - cap_t[n1-1] : -1, IFG + 1);
        end
        checks++;
        if (rdy_t.size() != 134 || done_t.size() != 2) begin
            errors++;
            $display("FAIL b2b_ready: got %0d ready cycles %0d done, need 134 and 2", rdy_t.size(), done_t.size());
        end
    endtask

    task automatic test_underrun();
        byte_q_t f;
        int d;
        clear_mon();
        f = make_frame(40);
        repeat (7) exp_q.push_back(8'h55);
        exp_q.push_back(8'hD5);
        for (int i = 0; i < 21; i++) exp_q.push_back(f[i]);
        drive(0, f, lasts_for(40), 21);
        wait_quiet(0, 1);
        d = first_diff(cap_q, exp_q);
        checks++;
        if (d != -1) begin
            errors++;
            $display("FAIL urun_stream: idx %0d len %0d need %0d", d, cap_q.size(), exp_q.size());
        end
        checks++;
        if (urun_t.size() != 1 || cap_t.size() == 0 || urun_t[0] != cap_t[cap_t.size()-1] + 1 || done_t.size() != 0) begin
            errors++;
            $display("FAIL urun_pulse: got %0d pulses %0d done, need 1 right after last byte and 0", urun_t.size(), done_t.size());
        end
        checks++;
        if (urun_t.size() < 1 || idle_cyc - urun_t[0] != IFG) begin
            errors++;
            $display("FAIL urun_ifg: got idle after %0d need %0d", idle_cyc - urun_t[0], IFG);
        end
        clear_mon();
        f = make_frame(30);
        exp_q = wire_image(f, 1'b1);
        drive(0, f, lasts_for(30), -1);
        wait_quiet(1, 0);
        d = first_diff(cap_q, exp_q);
        checks++;
        if (d != -1 || crc_raw(cap_q, 8) !== 32'hDEBB_20E3) begin
            errors++;
            $display("FAIL urun_next_frame: idx %0d residue %h need -1 DEBB20E3", d, crc_raw(cap_q, 8));
        end
    endtask

    task automatic test_reset_mid();
        byte_q_t f;
        int d;
        clear_mon();
        f = make_frame(20);
        drive(0, f, lasts_for(20), -1);
        repeat (3) @(posedge tx_clk);
        #2;
        checks++;
        if (tx_valid_w[0] !== 1'b1 || tx_data_w[0] !== 8'h00 || state_w[0] === idle_state) begin
            errors++;
            $display("FAIL mid_pad_active: got v=%b d=%h, need 1 00", tx_valid_w[0], tx_data_w[0]);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (tx_valid_w[0] !== 1'b0 || tx_data_w[0] !== 8'h00 || in_ready_w[0] !== 1'b0 ||
            busy_w[0] !== 1'b0 || frame_done_w[0] !== 1'b0 || underrun_w[0] !== 1'b0 ||
            state_w[0] !== idle_state) begin
            errors++;
            $display("FAIL mid_reset: got v=%b d=%h rdy=%b busy=%b, need all 0",
                     tx_valid_w[0], tx_data_w[0], in_ready_w[0], busy_w[0]);
        end
        @(negedge tx_clk);
        rst_n = 1'b1;
        @(negedge tx_clk);
        clear_mon();
        f = make_frame(64);
        exp_q = wire_image(f, 1'b1);
        drive(0, f, lasts_for(64), -1);
        wait_quiet(1, 0);
        d = first_diff(cap_q, exp_q);
        checks++;
        if (d != -1 || crc_raw(cap_q, 8) !== 32'hDEBB_20E3) begin
            errors++;
            $display("FAIL post_reset_frame: idx %0d residue %h", d, crc_raw(cap_q, 8));
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_crc_check();
        test_padding();
        test_boundary();
        test_back_to_back();
        test_underrun();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
